// File: rtl/pattern_seq_pkg.sv
// Shared types and reset-default table contents for the pattern_seq block.
// Optional beat counter is controlled by the PATSEQ_BEAT_CNT_EN macro (see pattern_seq.sv).
package pattern_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 8;

   typedef struct packed {
      logic                  dv;
      logic [DEF_DATA_W-1:0] data;
   } slot_t;

   localparam int unsigned DEF_A_IDX = 0;
   localparam slot_t       DEF_A     = '{dv: 1'b1, data: 8'h07};
   localparam int unsigned DEF_B_IDX = 2;
   localparam slot_t       DEF_B     = '{dv: 1'b1, data: 8'h05};

   function automatic logic default_dv(input int unsigned idx);
      if (idx == DEF_A_IDX) return DEF_A.dv;
      if (idx == DEF_B_IDX) return DEF_B.dv;
      return 1'b0;
   endfunction

   function automatic logic [DEF_DATA_W-1:0] default_data(input int unsigned idx);
      if (idx == DEF_A_IDX) return DEF_A.data;
      if (idx == DEF_B_IDX) return DEF_B.data;
      return '0;
   endfunction

endpackage

// File: rtl/pattern_seq_table.sv
// DEPTH-slot {dv, data} register file: reset defaults, one synchronous write
// port and one combinational read port (a same-cycle read returns the old value).
module pattern_seq_table
   import pattern_seq_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic              i_wdv,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic              o_rdv,
   output logic [DATA_W-1:0] o_rdata
);

   logic              dv_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            dv_q[i]   <= default_dv(unsigned'(i));
            data_q[i] <= DATA_W'(default_data(unsigned'(i)));
         end
      end else if (i_we) begin
         dv_q[i_waddr]   <= i_wdv;
         data_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdv   = dv_q[i_raddr];
   assign o_rdata = data_q[i_raddr];

endmodule

// File: rtl/pattern_seq.sv
// Programmable pattern sequencer: replays table slots 0..len with backpressure.
// Define PATSEQ_BEAT_CNT_EN to add the saturating accepted-beat counter o_beat_cnt.
//
// state | meaning
// IDLE  | output register empty, waiting for i_start
// RUN   | replaying slots; output register holds the current beat
module pattern_seq
   import pattern_seq_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 8,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_mode,
   input  logic [IDX_W-1:0]  i_len,
   input  logic              i_cfg_we,
   input  logic [IDX_W-1:0]  i_cfg_addr,
   input  logic              i_cfg_dv,
   input  logic [DATA_W-1:0] i_cfg_data,
   input  logic              i_ready,
   output logic              o_dv,
   output logic [DATA_W-1:0] o_data,
   output logic              o_busy,
   output logic              o_done
`ifdef PATSEQ_BEAT_CNT_EN
   ,
   output logic [15:0]       o_beat_cnt
`endif
);

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic [IDX_W-1:0]  len_q, len_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              dv_q, dv_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;
   logic              stop_q, stop_d;
   logic              done_q, done_d;

   logic [IDX_W-1:0]  rd_addr;
   logic              rd_dv;
   logic [DATA_W-1:0] rd_data;
   logic              advance;
   logic              stop_eff;

   pattern_seq_table #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_table (
      .sclk    (sclk),
      .rst_n   (rst_n),
      .i_we    (i_cfg_we),
      .i_waddr (i_cfg_addr),
      .i_wdv   (i_cfg_dv),
      .i_wdata (i_cfg_data),
      .i_raddr (rd_addr),
      .o_rdv   (rd_dv),
      .o_rdata (rd_data)
   );

   // IDLE always looks at slot 0 so a start can load the first beat directly.
   assign rd_addr  = (state_q == IDLE) ? '0 : idx_q;
   assign advance  = !dv_q || i_ready;
   assign stop_eff = stop_q || i_stop;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      len_d   = len_q;
      idx_d   = idx_q;
      dv_d    = dv_q;
      data_d  = data_q;
      last_d  = last_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = RUN;
               mode_d  = i_mode;
               len_d   = i_len;
               stop_d  = 1'b0;
               dv_d    = rd_dv;
               data_d  = rd_dv ? rd_data : '0;
               last_d  = (i_len == '0);
               idx_d   = (i_len == '0) ? '0 : IDX_W'(1);
            end
         end
         RUN: begin
            if (advance) begin
               if (stop_eff || (mode_q && last_q)) begin
                  state_d = IDLE;
                  dv_d    = 1'b0;
                  data_d  = '0;
                  stop_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  dv_d   = rd_dv;
                  data_d = rd_dv ? rd_data : '0;
                  last_d = (idx_q == len_q);
                  idx_d  = (idx_q == len_q) ? '0 : idx_q + 1'b1;
               end
            end else begin
               stop_d = stop_eff;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         len_q   <= '0;
         idx_q   <= '0;
         dv_q    <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         stop_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         dv_q    <= dv_d;
         data_q  <= data_d;
         last_q  <= last_d;
         stop_q  <= stop_d;
         done_q  <= done_d;
      end
   end

   assign o_dv   = dv_q;
   assign o_data = data_q;
   assign o_busy = (state_q == RUN);
   assign o_done = done_q;

`ifdef PATSEQ_BEAT_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == IDLE) && i_start) begin
         cnt_d = '0;
      end else if (dv_q && i_ready && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pattern_seq.sv
// Self-checking bench for pattern_seq: directed test-plan steps followed by a
// randomized phase, all checked against a slot-stream reference model.
module tb_pattern_seq;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int IDX_W  = 3;

   logic              sclk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_start = 1'b0;
   logic              i_stop = 1'b0;
   logic              i_mode = 1'b0;
   logic [IDX_W-1:0]  i_len = '0;
   logic              i_cfg_we = 1'b0;
   logic [IDX_W-1:0]  i_cfg_addr = '0;
   logic              i_cfg_dv = 1'b0;
   logic [DATA_W-1:0] i_cfg_data = '0;
   logic              i_ready = 1'b1;
   logic              o_dv;
   logic [DATA_W-1:0] o_data;
   logic              o_busy;
   logic              o_done;
`ifdef PATSEQ_BEAT_CNT_EN
   logic [15:0]       o_beat_cnt;
`endif

   pattern_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .sclk       (sclk),
      .rst_n      (rst_n),
      .i_start    (i_start),
      .i_stop     (i_stop),
      .i_mode     (i_mode),
      .i_len      (i_len),
      .i_cfg_we   (i_cfg_we),
      .i_cfg_addr (i_cfg_addr),
      .i_cfg_dv   (i_cfg_dv),
      .i_cfg_data (i_cfg_data),
      .i_ready    (i_ready),
      .o_dv       (o_dv),
      .o_data     (o_data),
      .o_busy     (o_busy),
      .o_done     (o_done)
`ifdef PATSEQ_BEAT_CNT_EN
      ,
      .o_beat_cnt (o_beat_cnt)
`endif
   );

   always #5 sclk = ~sclk;

   int checks = 0;
   int errors = 0;

   // Reference model: the beat on the output is described by how many slots
   // have been presented since start (m_k); slot = k mod (len+1).
   bit         m_busy = 0;
   logic       m_dv = 0;
   logic [7:0] m_data = 0;
   bit         m_done = 0;
   bit         m_mode = 0;
   int         m_len = 0;
   int         m_k = 0;
   bit         m_stop = 0;
   int         m_cnt = 0;
   logic       m_tdv   [DEPTH];
   logic [7:0] m_tdata [DEPTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic       n_dv;
      logic [7:0] n_data;
      bit         n_done;
      int         slot;
      n_dv   = m_dv;
      n_data = m_data;
      n_done = 0;
      if (!rst_n) begin
         m_busy = 0; n_dv = 0; n_data = 0; m_k = 0; m_stop = 0; m_cnt = 0;
         for (int i = 0; i < DEPTH; i++) begin
            m_tdv[i] = 0; m_tdata[i] = 0;
         end
         m_tdv[0] = 1; m_tdata[0] = 8'h07;
         m_tdv[2] = 1; m_tdata[2] = 8'h05;
      end else begin
         if (m_dv && i_ready && m_cnt < 65535) m_cnt++;
         if (!m_busy) begin
            if (i_start) begin
               m_busy = 1; m_mode = i_mode; m_len = int'(i_len);
               m_k = 1; m_stop = 0; m_cnt = 0;
               n_dv = m_tdv[0];
               n_data = n_dv ? m_tdata[0] : 8'h00;
            end
         end else if (!m_dv || i_ready) begin
            if (m_stop || i_stop || (m_mode && m_k == m_len + 1)) begin
               m_busy = 0; n_dv = 0; n_data = 0; n_done = 1;
            end else begin
               slot = m_k % (m_len + 1);
               n_dv = m_tdv[slot];
               n_data = n_dv ? m_tdata[slot] : 8'h00;
               m_k++;
            end
         end else if (i_stop) begin
            m_stop = 1;
         end
         if (i_cfg_we) begin
            m_tdv[i_cfg_addr]   = i_cfg_dv;
            m_tdata[i_cfg_addr] = i_cfg_data;
         end
      end
      @(posedge sclk);
      #1;
      m_dv = n_dv; m_data = n_data; m_done = n_done;
      chk("dv", 32'(o_dv), 32'(m_dv));
      chk("data", 32'(o_data), 32'(m_data));
      chk("busy", 32'(o_busy), 32'(m_busy));
      chk("done", 32'(o_done), 32'(m_done));
`ifdef PATSEQ_BEAT_CNT_EN
      chk("beat_cnt", 32'(o_beat_cnt), 32'(m_cnt));
`endif
   endtask

   task automatic cfg_write(input int addr, input logic dv, input logic [7:0] data);
      i_cfg_we = 1; i_cfg_addr = IDX_W'(addr); i_cfg_dv = dv; i_cfg_data = data;
      step();
      i_cfg_we = 0;
   endtask

   task automatic start(input logic mode, input int len);
      i_start = 1; i_mode = mode; i_len = IDX_W'(len);
      step();
      i_start = 0;
   endtask

   task automatic stop();
      i_stop = 1;
      step();
      i_stop = 0;
   endtask

   logic [7:0] exp_t1_data [4] = '{8'h07, 8'h00, 8'h05, 8'h00};
   logic       exp_t1_dv   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [7:0] exp_t2      [4] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};

   initial begin
      rst_n = 0;
      step();
      step();
      chk("rst_dv", 32'(o_dv), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      rst_n = 1;
      step();

      // Defaults, one-shot, len=3
      i_ready = 1;
      start(1'b1, 3);
      for (int i = 0; i < 4; i++) begin
         chk("t1_dv", 32'(o_dv), 32'(exp_t1_dv[i]));
         chk("t1_data", 32'(o_data), 32'(exp_t1_data[i]));
         step();
      end
      chk("t1_done", 32'(o_done), 32'd1);
      chk("t1_busy", 32'(o_busy), 32'd0);
      step();

      // Programmed loop, no gaps, then stop
      cfg_write(0, 1, 8'hA5);
      cfg_write(1, 1, 8'h3C);
      cfg_write(2, 1, 8'h0F);
      cfg_write(3, 1, 8'hF0);
      start(1'b0, 3);
      for (int i = 0; i < 10; i++) begin
         chk("t2_data", 32'(o_data), 32'(exp_t2[i % 4]));
         step();
      end
      stop();
      chk("t2_stop_done", 32'(o_done), 32'd1);
      step();

      // Backpressure hold on 3C
      start(1'b0, 3);
      step();
      i_ready = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold", 32'(o_data), 32'h3C);
      end
      i_ready = 1;
      step();
      chk("bp_release", 32'(o_data), 32'h0F);
      stop();
      step();

      // len = 0
      cfg_write(0, 1, 8'h55);
      start(1'b1, 0);
      chk("len0_beat", 32'(o_data), 32'h55);
      step();
      chk("len0_done", 32'(o_done), 32'd1);
      start(1'b0, 0);
      repeat (5) step();
      chk("len0_loop", 32'(o_data), 32'h55);
      stop();
      step();

      // Config write to slot 2 as it is loaded; start during RUN ignored
      cfg_write(0, 1, 8'hA5);
      start(1'b0, 3);
      step();
      cfg_write(2, 1, 8'h99);
      chk("wr_old", 32'(o_data), 32'h0F);
      i_start = 1;
      step();
      i_start = 0;
      repeat (3) step();
      chk("wr_new", 32'(o_data), 32'h99);
      repeat (3) step();

      // Reset mid-run restores defaults
      rst_n = 0;
      step();
      chk("mrst_dv", 32'(o_dv), 32'd0);
      chk("mrst_busy", 32'(o_busy), 32'd0);
      rst_n = 1;
      start(1'b1, 3);
      repeat (6) step();

      // Randomized phase
      for (int c = 0; c < 4000; c++) begin
         i_ready    = ($urandom_range(0, 3) != 0);
         i_start    = ($urandom_range(0, 15) == 0);
         i_stop     = ($urandom_range(0, 39) == 0);
         i_mode     = 1'($urandom_range(0, 1));
         i_len      = IDX_W'($urandom_range(0, DEPTH - 1));
         i_cfg_we   = ($urandom_range(0, 7) == 0);
         i_cfg_addr = IDX_W'($urandom_range(0, DEPTH - 1));
         i_cfg_dv   = 1'($urandom_range(0, 1));
         i_cfg_data = 8'($urandom);
         rst_n      = ($urandom_range(0, 599) != 0);
         step();
      end
      rst_n = 1; i_start = 0; i_stop = 0; i_cfg_we = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
